// File: rtl/arcabuco_core_pack.sv
// Shared Arcabuco core types: memory access sizes, LSU FSM states
// and the alignment helper used by the MEM stage.
package arcabuco_core_pack;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } t_mem_size;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } t_lsu_state;

    function automatic logic is_misaligned(
        input t_mem_size  size,
        input logic [1:0] off
    );
        case (size)
            MEM_H:   return off[0];
            MEM_W:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU: byte enables, store lane replication
// and load extract/extend. LOAD selects which data result drives dout.
// Ports: size/uns/offset control, din -> be (enables), dout (data).
module lsu_align
    import arcabuco_core_pack::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  t_mem_size   size,
    input  logic        uns,
    input  logic [1:0]  offset,
    input  logic [31:0] din,
    output logic [3:0]  be,
    output logic [31:0] dout
);

    logic [31:0] shifted;
    logic [31:0] ext;
    logic [31:0] rep;

    always_comb begin
        shifted = din >> {offset, 3'b000};
        be      = 4'b1111;
        rep     = din;
        ext     = shifted;
        case (size)
            MEM_B: begin
                be  = 4'b0001 << offset;
                rep = {4{din[7:0]}};
                ext = {{24{~uns & shifted[7]}}, shifted[7:0]};
            end
            MEM_H: begin
                be  = 4'b0011 << offset;
                rep = {2{din[15:0]}};
                ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign dout = LOAD ? ext : rep;

endmodule

// File: rtl/arcabuco_memory.sv
// Arcabuco MEM-stage load/store unit: EX->MEM consumer driving a
// req/gnt/rvalid data bus, with load extension and pipeline stall.
// Ports: clock/rst, mem_* request from EX, dbus_* bus, load_data/
// load_valid to WB, mem_busy stall, misaligned/bus_error pulses.
// Option: ARCABUCO_MISALIGN_TRAP_EN rejects misaligned H/W accesses;
// otherwise low address bits are forced to the access size.
module arcabuco_memory
    import arcabuco_core_pack::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  t_mem_size         mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    input  logic              memory_access,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_err,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              mem_busy,
    output logic              misaligned,
    output logic              bus_error
);

    t_lsu_state        state;
    logic [1:0]        off;
    logic              aligned;
    logic              issue;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [3:0]        ld_be_unused;
    logic [31:0]       ld_ext;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_we;
    t_mem_size         r_size;
    logic              r_uns;
    logic [1:0]        r_off;

`ifdef ARCABUCO_MISALIGN_TRAP_EN
    assign off     = addr[1:0];
    assign aligned = ~is_misaligned(mem_size, addr[1:0]);
`else
    // Without the trap, H keeps only addr[1] and W ignores both bits.
    always_comb begin
        case (mem_size)
            MEM_W:   off = 2'b00;
            MEM_H:   off = {addr[1], 1'b0};
            default: off = addr[1:0];
        endcase
    end
    assign aligned = 1'b1;
`endif

    assign issue = (state == IDLE) & mem_valid & aligned;

    lsu_align #(.LOAD(1'b0)) u_st_align (
        .size   (mem_size),
        .uns    (1'b0),
        .offset (off),
        .din    (wr_data),
        .be     (st_be),
        .dout   (st_wdata)
    );

    lsu_align #(.LOAD(1'b1)) u_ld_align (
        .size   (r_size),
        .uns    (r_uns),
        .offset (r_off),
        .din    (dbus_rdata),
        .be     (ld_be_unused),
        .dout   (ld_ext)
    );

    // First request cycle comes straight from EX; REQ replays the
    // captured copy so fields stay stable until grant.
    always_comb begin
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_be    = 4'b0000;
        dbus_wdata = 32'h0;
        if (issue) begin
            dbus_req   = 1'b1;
            dbus_we    = mem_we;
            dbus_addr  = {addr[ADDR_W-1:2], 2'b00};
            dbus_be    = st_be;
            dbus_wdata = st_wdata;
        end else if (state == REQ) begin
            dbus_req   = 1'b1;
            dbus_we    = r_we;
            dbus_addr  = r_addr;
            dbus_be    = r_be;
            dbus_wdata = r_wdata;
        end
    end

    // Known-latency accesses granted at once do not stall on issue.
    assign mem_busy =
        ((state != IDLE) & ~((state == WAIT) & dbus_rvalid)) |
        (issue & (memory_access | ~dbus_gnt));

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
            r_we       <= 1'b0;
            r_size     <= MEM_B;
            r_uns      <= 1'b0;
            r_off      <= 2'b00;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
`ifdef ARCABUCO_MISALIGN_TRAP_EN
            misaligned <= (state == IDLE) & mem_valid & ~aligned;
`else
            misaligned <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (issue) begin
                        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_be    <= st_be;
                        r_wdata <= st_wdata;
                        r_we    <= mem_we;
                        r_size  <= mem_size;
                        r_uns   <= mem_unsigned;
                        r_off   <= off;
                        state   <= dbus_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (dbus_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (dbus_rvalid) begin
                        load_valid <= 1'b1;
                        bus_error  <= dbus_err;
                        load_data  <= dbus_err ? 32'h0 : ld_ext;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arcabuco_memory.sv
// Self-checking bench for arcabuco_memory: vector table, directed
// corner sequences and random transactions against a reference model.
module tb_arcabuco_memory;
    import arcabuco_core_pack::*;

    logic        clock = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    t_mem_size   mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        memory_access;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        dbus_err;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_busy;
    logic        misaligned;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;

    arcabuco_memory #(.ADDR_W(32)) dut (
        .clock         (clock),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .addr          (addr),
        .wr_data       (wr_data),
        .memory_access (memory_access),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_be       (dbus_be),
        .dbus_wdata    (dbus_wdata),
        .dbus_gnt      (dbus_gnt),
        .dbus_rvalid   (dbus_rvalid),
        .dbus_rdata    (dbus_rdata),
        .dbus_err      (dbus_err),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .mem_busy      (mem_busy),
        .misaligned    (misaligned),
        .bus_error     (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        t_mem_size   sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_valid     = 1'b0;
        mem_we        = 1'b0;
        mem_size      = MEM_B;
        mem_unsigned  = 1'b0;
        addr          = 32'h0;
        wr_data       = 32'h0;
        memory_access = 1'b0;
        dbus_gnt      = 1'b0;
        dbus_rvalid   = 1'b0;
        dbus_rdata    = 32'h0;
        dbus_err      = 1'b0;
    endtask

    // Reference: effective lane offset after size forcing
    function automatic logic [1:0] m_off(input t_mem_size s,
                                         input logic [31:0] a);
        if (s == MEM_W) return 2'b00;
        if (s == MEM_H) return {a[1], 1'b0};
        return a[1:0];
    endfunction

    function automatic logic [3:0] m_be(input t_mem_size s,
                                        input logic [1:0] o);
        int unsigned w;
        w = (s == MEM_W) ? 15 : (s == MEM_H) ? 3 : 1;
        return 4'((w << o) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input t_mem_size s,
                                            input logic [31:0] wd);
        if (s == MEM_B) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == MEM_H) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input t_mem_size s,
                                           input logic uns,
                                           input logic [1:0] o,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * o);
        if (s == MEM_B) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (s == MEM_H) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    task automatic run_txn(
        input string       tag,
        input logic        we,
        input t_mem_size   sz,
        input logic        uns,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input logic        acc,
        input int          gdly,
        input int          rdly,
        input logic        err,
        input logic [3:0]  ebe,
        input logic [31:0] ewd,
        input logic [31:0] eld
    );
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        @(negedge clock);
        mem_valid     = 1'b1;
        mem_we        = we;
        mem_size      = sz;
        mem_unsigned  = uns;
        addr          = a;
        wr_data       = wd;
        memory_access = acc;
        dbus_gnt      = (gdly == 0);
        dbus_rvalid   = 1'b0;
        dbus_err      = 1'b0;
        #1;
        chk($sformatf("%s req", tag), dbus_req, 1);
        chk($sformatf("%s addr", tag), dbus_addr, wa);
        chk($sformatf("%s be", tag), dbus_be, ebe);
        chk($sformatf("%s wdata", tag), dbus_wdata, ewd);
        chk($sformatf("%s we", tag), dbus_we, we);
        chk($sformatf("%s busy0", tag), mem_busy,
            acc | (gdly != 0));
        for (int i = 1; i <= gdly; i++) begin
            @(negedge clock);
            addr     = $urandom;
            wr_data  = $urandom;
            dbus_gnt = (i == gdly);
            #1;
            chk($sformatf("%s hreq%0d", tag, i), dbus_req, 1);
            chk($sformatf("%s haddr%0d", tag, i), dbus_addr, wa);
            chk($sformatf("%s hbe%0d", tag, i), dbus_be, ebe);
            chk($sformatf("%s hwd%0d", tag, i), dbus_wdata, ewd);
            chk($sformatf("%s hbusy%0d", tag, i), mem_busy, 1);
        end
        for (int j = 1; j <= rdly; j++) begin
            @(negedge clock);
            mem_valid   = 1'b0;
            dbus_gnt    = 1'b0;
            dbus_rvalid = (j == rdly);
            dbus_rdata  = (j == rdly) ? rd : $urandom;
            dbus_err    = (j == rdly) & err;
            #1;
            chk($sformatf("%s wreq%0d", tag, j), dbus_req, 0);
            chk($sformatf("%s wbusy%0d", tag, j), mem_busy, j != rdly);
            chk($sformatf("%s wlv%0d", tag, j), load_valid, 0);
            chk($sformatf("%s wmis%0d", tag, j), misaligned, 0);
            chk($sformatf("%s wberr%0d", tag, j), bus_error, 0);
        end
        @(negedge clock);
        drive_idle();
        #1;
        chk($sformatf("%s lvalid", tag), load_valid, 1);
        chk($sformatf("%s buserr", tag), bus_error, err);
        chk($sformatf("%s busy_end", tag), mem_busy, 0);
        if (!we)
            chk($sformatf("%s ldata", tag), load_data,
                err ? 32'h0 : eld);
    endtask

    initial begin
        vecs[0] = '{1'b1, MEM_B, 1'b0, 32'h2000_0003, 32'hFFFF_FFAB,
                    32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1] = '{1'b1, MEM_H, 1'b0, 32'h2000_0002, 32'hAAAA_1234,
                    32'h0, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[2] = '{1'b1, MEM_W, 1'b0, 32'h2000_0004, 32'hDEAD_BEEF,
                    32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b0, MEM_B, 1'b0, 32'h1000_0001, 32'h0,
                    32'h0000_80FF, 4'b0010, 32'h0, 32'hFFFF_FF80};
        vecs[4] = '{1'b0, MEM_B, 1'b1, 32'h1000_0001, 32'h0,
                    32'h0000_80FF, 4'b0010, 32'h0, 32'h0000_0080};
        vecs[5] = '{1'b0, MEM_H, 1'b0, 32'h1000_0002, 32'h0,
                    32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001};
        vecs[6] = '{1'b0, MEM_H, 1'b1, 32'h1000_0000, 32'h0,
                    32'h1234_F00D, 4'b0011, 32'h0, 32'h0000_F00D};
        vecs[7] = '{1'b0, MEM_W, 1'b0, 32'h1000_0008, 32'h0,
                    32'hCAFE_BABE, 4'b1111, 32'h0, 32'hCAFE_BABE};
        vecs[8] = '{1'b0, MEM_B, 1'b0, 32'h1000_0003, 32'h0,
                    32'h7F00_0000, 4'b1000, 32'h0, 32'h0000_007F};

        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk("rst req", dbus_req, 0);
        chk("rst we", dbus_we, 0);
        chk("rst addr", dbus_addr, 0);
        chk("rst be", dbus_be, 0);
        chk("rst wdata", dbus_wdata, 0);
        chk("rst ldata", load_data, 0);
        chk("rst lvalid", load_valid, 0);
        chk("rst busy", mem_busy, 0);
        chk("rst mis", misaligned, 0);
        chk("rst berr", bus_error, 0);

        // Known-latency region, same-cycle grant, next-cycle response
        for (int v = 0; v < 9; v++)
            run_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].sz,
                    vecs[v].uns, vecs[v].a, vecs[v].wd, vecs[v].rd,
                    1'b0, 0, 1, 1'b0, vecs[v].be, vecs[v].wdat,
                    vecs[v].ld);

        run_txn("sb_var", 1'b1, MEM_B, 1'b0, 32'h2000_0003,
                32'h0000_00AB, 32'h0, 1'b1, 0, 2, 1'b0,
                4'b1000, 32'hABAB_ABAB, 32'h0);
        run_txn("lw_gnt3", 1'b0, MEM_W, 1'b0, 32'h2000_0010,
                32'h0, 32'h1357_9BDF, 1'b1, 3, 1, 1'b0,
                4'b1111, 32'h0, 32'h1357_9BDF);
        run_txn("lw_tcm_late", 1'b0, MEM_W, 1'b0, 32'h0000_0100,
                32'h0, 32'h2468_ACE0, 1'b0, 0, 3, 1'b0,
                4'b1111, 32'h0, 32'h2468_ACE0);
        run_txn("lw_err", 1'b0, MEM_W, 1'b0, 32'h2000_0020,
                32'h0, 32'hFFFF_FFFF, 1'b1, 1, 2, 1'b1,
                4'b1111, 32'h0, 32'h0);

`ifdef ARCABUCO_MISALIGN_TRAP_EN
        @(negedge clock);
        mem_valid = 1'b1;
        mem_size  = MEM_H;
        addr      = 32'h3000_0001;
        dbus_gnt  = 1'b1;
        #1;
        chk("misH req", dbus_req, 0);
        chk("misH busy", mem_busy, 0);
        chk("misH early", misaligned, 0);
        @(negedge clock);
        drive_idle();
        #1;
        chk("misH pulse", misaligned, 1);
        chk("misH lv", load_valid, 0);
        @(negedge clock);
        mem_valid = 1'b1;
        mem_size  = MEM_W;
        addr      = 32'h3000_0006;
        #1;
        chk("misW req", dbus_req, 0);
        chk("misH clear", misaligned, 0);
        @(negedge clock);
        drive_idle();
        #1;
        chk("misW pulse", misaligned, 1);
        @(negedge clock);
        #1;
        chk("misW clear", misaligned, 0);
`else
        run_txn("lh_odd", 1'b0, MEM_H, 1'b0, 32'h3000_0001,
                32'h0, 32'h1234_ABCD, 1'b0, 0, 1, 1'b0,
                4'b0011, 32'h0, 32'hFFFF_ABCD);
        chk("lh_odd mis", misaligned, 0);
        run_txn("lw_odd", 1'b0, MEM_W, 1'b0, 32'h3000_0006,
                32'h0, 32'h89AB_CDEF, 1'b0, 0, 1, 1'b0,
                4'b1111, 32'h0, 32'h89AB_CDEF);
`endif

        // Response and next mem_valid in the same cycle
        @(negedge clock);
        mem_valid = 1'b1;
        mem_size  = MEM_W;
        addr      = 32'h4000_0000;
        dbus_gnt  = 1'b1;
        #1;
        chk("b2b req0", dbus_req, 1);
        chk("b2b busy0", mem_busy, 0);
        @(negedge clock);
        mem_size     = MEM_B;
        mem_unsigned = 1'b1;
        addr         = 32'h4000_0005;
        dbus_rvalid  = 1'b1;
        dbus_rdata   = 32'h1122_3344;
        #1;
        chk("b2b noissue", dbus_req, 0);
        chk("b2b busy1", mem_busy, 0);
        @(negedge clock);
        dbus_rvalid = 1'b0;
        #1;
        chk("b2b req2", dbus_req, 1);
        chk("b2b addr2", dbus_addr, 32'h4000_0004);
        chk("b2b be2", dbus_be, 4'b0010);
        chk("b2b lv2", load_valid, 1);
        chk("b2b ld2", load_data, 32'h1122_3344);
        @(negedge clock);
        mem_valid   = 1'b0;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0000_AB00;
        #1;
        chk("b2b busy3", mem_busy, 0);
        @(negedge clock);
        drive_idle();
        #1;
        chk("b2b lv4", load_valid, 1);
        chk("b2b ld4", load_data, 32'h0000_00AB);

        // Reset while waiting for a response
        @(negedge clock);
        mem_valid     = 1'b1;
        mem_size      = MEM_W;
        addr          = 32'h5000_0010;
        memory_access = 1'b1;
        dbus_gnt      = 1'b1;
        #1;
        chk("rw busy0", mem_busy, 1);
        @(negedge clock);
        mem_valid = 1'b0;
        dbus_gnt  = 1'b0;
        #1;
        chk("rw busy1", mem_busy, 1);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        drive_idle();
        #1;
        chk("rw req", dbus_req, 0);
        chk("rw we", dbus_we, 0);
        chk("rw addr", dbus_addr, 0);
        chk("rw be", dbus_be, 0);
        chk("rw wdata", dbus_wdata, 0);
        chk("rw ldata", load_data, 0);
        chk("rw lvalid", load_valid, 0);
        chk("rw busy", mem_busy, 0);
        chk("rw mis", misaligned, 0);
        chk("rw berr", bus_error, 0);
        run_txn("post_rst", 1'b0, MEM_H, 1'b1, 32'h5000_0002,
                32'h0, 32'hBEEF_0000, 1'b0, 0, 1, 1'b0,
                4'b1100, 32'h0, 32'h0000_BEEF);

        for (int k = 0; k < 150; k++) begin
            t_mem_size   s;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            logic [1:0]  o;
            logic        we;
            logic        uns;
            logic        acc;
            logic        err;
            int          g;
            int          r;
            case ($urandom_range(2))
                0:       s = MEM_B;
                1:       s = MEM_H;
                default: s = MEM_W;
            endcase
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            we  = 1'($urandom_range(1));
            uns = 1'($urandom_range(1));
            acc = 1'($urandom_range(1));
            err = ($urandom_range(7) == 0);
            g   = $urandom_range(3);
            r   = $urandom_range(3, 1);
`ifdef ARCABUCO_MISALIGN_TRAP_EN
            if (s == MEM_W) a[1:0] = 2'b00;
            if (s == MEM_H) a[0] = 1'b0;
`endif
            o = m_off(s, a);
            run_txn($sformatf("rnd%0d", k), we, s, uns, a, wd, rd,
                    acc, g, r, err, m_be(s, o), m_wdata(s, wd),
                    m_load(s, uns, o, rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arcabuco_memory.md
# arcabuco_memory

Load/store unit of the Arcabuco MEM stage: the consuming end of the EX→MEM interface. Takes the EX-stage effective address, store data and memory-access flag, and drives a req/gnt/rvalid data bus. Generates byte enables and aligned store data, and extracts and sign/zero-extends load data for WB. Stalls the pipeline while a transaction is outstanding; known-latency regions skip the stall bubble.

## Interface
Parameters:
- ADDR_W, 32, address width (only 32 supported)

Ports:
- clock  in  1  core clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  EX/MEM holds a load or store this cycle
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  t_mem_size  MEM_B / MEM_H / MEM_W
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- addr  in  32  effective address (EX ALU result)
- wr_data  in  32  store data, unaligned, in low bits
- memory_access  in  1  1 = variable-latency region, 0 = known-latency (TCM/DPB)
- dbus_req  out  1  request valid
- dbus_we  out  1  write strobe
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-aligned store data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response (load data or store ack)
- dbus_rdata  in  32  load data, word
- dbus_err  in  1  bus error, qualified by dbus_rvalid
- load_data  out  32  extended load result to WB
- load_valid  out  1  one-cycle pulse: load_data valid / store completed
- mem_busy  out  1  stall request to pipeline control
- misaligned  out  1  one-cycle pulse: misaligned access rejected
- bus_error  out  1  one-cycle pulse: dbus_err returned

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: on mem_valid & aligned, assert dbus_req combinationally. If dbus_gnt, go to WAIT; otherwise go to REQ.
- REQ: hold dbus_req and all registered request fields (addr, be, wdata, we, size, unsigned). Go to WAIT on dbus_gnt.
- WAIT: dbus_req = 0. On dbus_rvalid, pulse load_valid (and bus_error if dbus_err), then go to IDLE.
- A response in WAIT may complete in the same cycle as a new mem_valid. Back-to-back issue from IDLE then begins the next cycle, never the same cycle.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
- Store data:
  - B: wr_data[7:0] replicated on all four lanes
  - H: wr_data[15:0] replicated on both halves
  - W: wr_data unchanged
- Load extraction: select the byte/half by the registered addr[1:0], then sign- or zero-extend to 32 bits per mem_unsigned. On error, load_data = 0.
- Misaligned: H with addr[0]=1, or W with addr[1:0]≠0. Such a request issues no bus request.
- mem_busy:
  - asserted when state≠IDLE and not (WAIT & dbus_rvalid)
  - also asserted in IDLE when mem_valid & aligned & (memory_access | ~dbus_gnt)
- memory_access=0 path: no stall on the issue cycle if granted. The response is required the next cycle; if it is absent, mem_busy asserts in WAIT until rvalid arrives.
- dbus_rvalid in IDLE/REQ is ignored. Verification asserts that it never occurs.

## Timing
- Reset values: state=IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0; load_data=0; load_valid=0; mem_busy=0; misaligned=0; bus_error=0.
- Variable region, gnt on the first cycle: request cycle 0, rvalid cycle ≥1. load_valid and load_data are registered and valid the cycle after rvalid. Minimum 2 cycles to load_valid.
- Known region: 0 stall cycles when gnt is same-cycle and rvalid is next-cycle.
- dbus_req, once asserted, stays high with stable fields until gnt.
- rst mid-transaction: FSM returns to IDLE and any outstanding response is discarded. The bus is assumed to be reset together with the core.

## Configuration
- ARCABUCO_MISALIGN_TRAP_EN defined:
  - misaligned accesses are rejected as described above
  - misaligned pulses one cycle after the offending mem_valid
  - mem_busy stays 0 for that access
- Not defined:
  - misaligned is tied to 0
  - addr[1:0] is forced to 0 for H/W sizes (H uses addr[1] only)
  - every access issues

## Structure
- arcabuco_core_pack receives:
  - typedef t_mem_size
  - typedef t_lsu_state
  - MEM_B / MEM_H / MEM_W encodings
  - reuse of the existing TCM_BASE/DPB_BASE constants; none redefined here
- One sub-module, lsu_align: combinational be/wdata generation and load extract/extend, instantiated once for each direction.

## Test plan
- SB 0xAB to 0x2000_0003, memory_access=1, gnt immediate, rvalid +2 → dbus_be=4'b1000, dbus_wdata=0xABABABAB, load_valid 1 cycle after rvalid.
- LB from a word 0x0000_80FF at offset 1, signed → load_data=0xFFFF_FF80; same with LBU → 0x0000_0080.
- LW with gnt delayed 3 cycles → dbus_req held 4 cycles with stable addr, mem_busy high throughout, load_data=dbus_rdata.
- LW to TCM (memory_access=0), gnt same cycle, rvalid next → mem_busy never asserted.
- LH at 0x...01 with ARCABUCO_MISALIGN_TRAP_EN → no dbus_req, misaligned pulses once. Without the macro → request at 0x...00, be=4'b0011.
- rvalid with dbus_err=1 → bus_error pulse, load_data=0. rst asserted in WAIT → IDLE next cycle, all outputs at reset values.
